// File: rtl/bt_cmd_parser_pkg.sv
// rtl/bt_cmd_parser_pkg.sv - shared constants and state encoding for the command parser
package bt_cmd_parser_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT   = 8'hA5;
    localparam int          PKT_LEN             = 5;
    localparam logic [31:0] GAP_TIMEOUT_DEFAULT = 32'd166700;

    // Command ids understood by the motor/servo control logic.
    localparam logic [7:0] CMD_DRIVE = 8'h01;
    localparam logic [7:0] CMD_STOP  = 8'h02;
    localparam logic [7:0] CMD_SERVO = 8'h03;

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ARG_A = 3'd2,
        ST_ARG_B = 3'd3,
        ST_CSUM  = 3'd4
    } parse_state_t;

endpackage

// File: rtl/bt_cmd_parser_byte_gap_timer.sv
// rtl/bt_cmd_parser_byte_gap_timer.sv - inter-byte gap counter with terminal-count pulse
module byte_gap_timer #(
    parameter logic [31:0] GAP_TIMEOUT = 32'd166700
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [31:0] count;

    // Saturates at GAP_TIMEOUT so the counter can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != GAP_TIMEOUT)) begin
            count <= count + 32'd1;
        end
    end

    // Fires on the cycle whose increment reaches GAP_TIMEOUT; a byte that cycle clears instead.
    assign tc = en && !clear && (count == GAP_TIMEOUT - 32'd1);

endmodule

// File: rtl/bt_cmd_parser.sv
// rtl/bt_cmd_parser.sv - frames UART bytes into checksummed 5-byte robot commands
module bt_cmd_parser
    import bt_cmd_parser_pkg::*;
#(
    parameter int          DATA_WIDTH  = 8,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter logic [31:0] GAP_TIMEOUT = GAP_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_done,
    output logic [7:0]            cmd_id,
    output logic [7:0]            arg_a,
    output logic [7:0]            arg_b,
    output logic                  cmd_valid,
    output logic                  cmd_err,
    output logic                  gap_err,
    output logic                  busy
);

    parse_state_t state;
    logic [7:0]   csum;
    logic [7:0]   sh_cmd;
    logic [7:0]   sh_a;
    logic [7:0]   sh_b;
    logic         gap_tc;
    logic         gap_clear;
    logic         gap_en;

    assign gap_clear = rx_done || (state == ST_SYNC);
    assign gap_en    = (state != ST_SYNC) && !rx_done;
    assign busy      = (state != ST_SYNC);

    byte_gap_timer #(
        .GAP_TIMEOUT(GAP_TIMEOUT)
    ) u_gap_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(gap_clear),
        .en   (gap_en),
        .tc   (gap_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_SYNC;
            csum      <= '0;
            sh_cmd    <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            cmd_id    <= '0;
            arg_a     <= '0;
            arg_b     <= '0;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            gap_err   <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            gap_err   <= 1'b0;
            if (rx_done) begin
                case (state)
                    ST_SYNC: begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= ST_CMD;
                            csum  <= '0;
                        end
                    end
                    ST_CMD: begin
                        sh_cmd <= rx_data;
                        csum   <= csum ^ rx_data;
                        state  <= ST_ARG_A;
                    end
                    ST_ARG_A: begin
                        sh_a  <= rx_data;
                        csum  <= csum ^ rx_data;
                        state <= ST_ARG_B;
                    end
                    ST_ARG_B: begin
                        sh_b  <= rx_data;
                        csum  <= csum ^ rx_data;
                        state <= ST_CSUM;
                    end
                    ST_CSUM: begin
                        // All three outputs move together so control never sees a mixed command.
                        if (rx_data == csum) begin
                            cmd_id    <= sh_cmd;
                            arg_a     <= sh_a;
                            arg_b     <= sh_b;
                            cmd_valid <= 1'b1;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                        state <= ST_SYNC;
                    end
                    default: state <= ST_SYNC;
                endcase
            end else if (gap_tc) begin
                gap_err <= 1'b1;
                state   <= ST_SYNC;
                csum    <= '0;
                sh_cmd  <= '0;
                sh_a    <= '0;
                sh_b    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bt_cmd_parser.sv
// tb/tb_bt_cmd_parser.sv - scoreboard bench for bt_cmd_parser
module tb_bt_cmd_parser;

    localparam int          SP   = 20;
    localparam logic [31:0] GT   = 32'd300;
    localparam int          T    = 300;
    localparam int          K_OK = 1;
    localparam int          K_CE = 2;
    localparam int          K_GE = 3;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] id;
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] cmd_id, arg_a, arg_b;
    logic       cmd_valid, cmd_err, gap_err, busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_rx = 0;
    ev_t  sb[$];
    logic [7:0] exp_id = 8'h00, exp_a = 8'h00, exp_b = 8'h00;

    bt_cmd_parser #(.GAP_TIMEOUT(GT)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .cmd_id(cmd_id), .arg_a(arg_a), .arg_b(arg_b),
        .cmd_valid(cmd_valid), .cmd_err(cmd_err), .gap_err(gap_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && (cmd_valid || cmd_err || gap_err)) begin
            ev_t e;
            int  ok;
            checks++;
            if ((int'(cmd_valid) + int'(cmd_err) + int'(gap_err)) != 1) begin
                errors++;
                $display("FAIL pulse_exclusive actual %b%b%b required one-hot", cmd_valid, cmd_err, gap_err);
            end
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse actual %b%b%b at cycle %0d required none", cmd_valid, cmd_err, gap_err, cyc);
            end else begin
                e  = sb.pop_front();
                ok = cmd_valid ? K_OK : (cmd_err ? K_CE : K_GE);
                checks++;
                if (ok != e.kind || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse_kind_cycle actual kind %0d cycle %0d required kind %0d cycle %0d", ok, cyc, e.kind, e.cyc);
                end
                if (e.kind == K_OK) begin
                    exp_id = e.id; exp_a = e.a; exp_b = e.b;
                end
                checks++;
                if ({cmd_id, arg_a, arg_b} !== {exp_id, exp_a, exp_b}) begin
                    errors++;
                    $display("FAIL cmd_outputs actual %h %h %h required %h %h %h", cmd_id, arg_a, arg_b, exp_id, exp_a, exp_b);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 1; i < gap; i++) begin
            @(posedge clk); #1;
        end
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        last_rx = cyc;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic send_seq(input logic [7:0] seq[$], input int gap);
        foreach (seq[i]) send_byte(seq[i], gap);
    endtask

    task automatic push_ev(input int kind, input int at, input logic [7:0] id,
                           input logic [7:0] a, input logic [7:0] b);
        ev_t e;
        e.kind = kind; e.cyc = at; e.id = id; e.a = a; e.b = b;
        sb.push_back(e);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        settle(2);
        checks++;
        if ({cmd_id, arg_a, arg_b, cmd_valid, cmd_err, gap_err, busy} !== 28'h0) begin
            errors++;
            $display("FAIL reset_state actual %h %h %h %b%b%b busy %b required all zero", cmd_id, arg_a, arg_b, cmd_valid, cmd_err, gap_err, busy);
        end
        rst = 1'b1;
        settle(3);
    endtask

    task automatic test_valid;
        logic [7:0] s[$] = '{8'hA5, 8'h01};
        send_seq(s, SP);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_packet actual %b required 1", busy); end
        s = '{8'h40, 8'hC0, 8'h81};
        send_seq(s, SP);
        push_ev(K_OK, last_rx, 8'h01, 8'h40, 8'hC0);
        settle(5);
        checks++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL valid_pending actual %0d busy %b required 0 0", sb.size(), busy); sb.delete();
        end
    endtask

    task automatic test_bad_csum;
        logic [7:0] s[$] = '{8'hA5, 8'h01, 8'h40, 8'hC0, 8'h80};
        send_seq(s, SP);
        push_ev(K_CE, last_rx, 8'h00, 8'h00, 8'h00);
        settle(5);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL bad_csum_pending actual %0d required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_garbage;
        logic [7:0] s[$] = '{8'h00, 8'hFF};
        send_seq(s, SP);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL garbage_busy actual %b required 0", busy); end
        s = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h02};
        send_seq(s, SP);
        push_ev(K_OK, last_rx, 8'h02, 8'h00, 8'h00);
        settle(5);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL garbage_pending actual %0d required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_gap;
        logic [7:0] s[$] = '{8'hA5, 8'h03};
        send_seq(s, SP);
        push_ev(K_GE, last_rx + T, 8'h00, 8'h00, 8'h00);
        settle(T + 5);
        checks++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL gap_pending actual %0d busy %b required 0 0", sb.size(), busy); sb.delete();
        end
        s = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h33};
        send_seq(s, SP);
        push_ev(K_OK, last_rx, 8'h03, 8'h10, 8'h20);
        settle(5);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL gap_recover_pending actual %0d required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_byte_wins;
        logic [7:0] s[$] = '{8'hA5, 8'h01};
        send_seq(s, SP);
        send_byte(8'h40, T);
        s = '{8'hC0, 8'h81};
        send_seq(s, SP);
        push_ev(K_OK, last_rx, 8'h01, 8'h40, 8'hC0);
        settle(5);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL byte_wins_pending actual %0d required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] s[$] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h02};
        send_seq(s, 1);
        push_ev(K_OK, last_rx, 8'h02, 8'h00, 8'h00);
        s = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h02};
        send_seq(s, 1);
        push_ev(K_OK, last_rx, 8'h01, 8'h01, 8'h02);
        settle(5);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL back_to_back_pending actual %0d required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_payload_sync;
        logic [7:0] s[$] = '{8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h01};
        send_seq(s, SP);
        push_ev(K_OK, last_rx, 8'hA5, 8'hA5, 8'h01);
        settle(5);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL payload_sync_pending actual %0d required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_async_reset;
        logic [7:0] s[$] = '{8'hA5, 8'h01};
        send_seq(s, SP);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({cmd_id, arg_a, arg_b, cmd_valid, cmd_err, gap_err, busy} !== 28'h0) begin
            errors++;
            $display("FAIL async_reset actual %h %h %h %b%b%b busy %b required all zero", cmd_id, arg_a, arg_b, cmd_valid, cmd_err, gap_err, busy);
        end
        exp_id = 8'h00; exp_a = 8'h00; exp_b = 8'h00;
        settle(3);
        rst = 1'b1;
        settle(2);
        s = '{8'hA5, 8'h03, 8'h7F, 8'h80, 8'hFC};
        send_seq(s, SP);
        push_ev(K_OK, last_rx, 8'h03, 8'h7F, 8'h80);
        settle(5);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL after_reset_pending actual %0d required 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        test_reset();
        test_valid();
        test_bad_csum();
        test_garbage();
        test_gap();
        test_byte_wins();
        test_back_to_back();
        test_payload_sync();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
